// File: rtl/dcache_pkg.sv
// Shared types and AXI constants for the data-cache writeback engine.
// The cache geometry (CACHE_B = log2 of line bytes) fixes the default line size.
package dcache_pkg;

  localparam int CACHE_B    = 4;
  localparam int LINE_WORDS = 2 ** (CACHE_B - 2);

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    RESP = 2'd3
  } wb_state_t;

endpackage

// File: rtl/dcache_writeback_if.sv
// Bundle of the cache-side writeback request and the AXI write channels.
// Modport master is the writeback engine (AXI master); slave is its environment.
interface dcache_writeback_if #(
  parameter int LINE_WORDS = 4,
  parameter int ADDR_WIDTH = 32
);

  // Every channel transfers on a rising clk edge where its valid and ready are
  // both high; a valid, once raised, holds its payload until that transfer.
  logic                         wb_req;
  logic [ADDR_WIDTH-1:0]        wb_addr;
  logic [LINE_WORDS*32-1:0]     wb_line;
  logic                         wb_ready;
  logic                         wb_done;
  logic                         wb_err;

  logic [ADDR_WIDTH-1:0]        awaddr;
  logic [7:0]                   awlen;
  logic [2:0]                   awsize;
  logic [1:0]                   awburst;
  logic                         awvalid;
  logic                         awready;

  logic [31:0]                  wdata;
  logic [3:0]                   wstrb;
  logic                         wlast;
  logic                         wvalid;
  logic                         wready;

  logic [1:0]                   bresp;
  logic                         bvalid;
  logic                         bready;

  modport master (
    input  wb_req, wb_addr, wb_line, awready, wready, bresp, bvalid,
    output wb_ready, wb_done, wb_err,
    output awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid, bready
  );

  modport slave (
    output wb_req, wb_addr, wb_line, awready, wready, bresp, bvalid,
    input  wb_ready, wb_done, wb_err,
    input  awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid, bready
  );

endinterface

// File: rtl/dcache_writeback.sv
// Writes one captured dirty cache line to memory as a single AXI INCR burst.
// All AXI outputs decode from registered state only, so no ready/valid input reaches an output.
module dcache_writeback #(
  parameter int LINE_WORDS = dcache_pkg::LINE_WORDS,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  dcache_writeback_if.master    bus,
  output dcache_pkg::wb_state_t dbg_state
);

  import dcache_pkg::*;

  localparam int BEAT_W = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;
  localparam logic [BEAT_W-1:0]     LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] OFFS_MASK = ADDR_WIDTH'(LINE_WORDS * 4 - 1);

  wb_state_t                state_q, state_d;
  logic [BEAT_W-1:0]        beat_q;
  logic [ADDR_WIDTH-1:0]    addr_q;
  logic [LINE_WORDS*32-1:0] line_q;
  logic                     done_q;
  logic                     err_q;

  logic accept, aw_hs, w_hs, b_hs;

  assign accept = bus.wb_req  & bus.wb_ready;
  assign aw_hs  = bus.awvalid & bus.awready;
  assign w_hs   = bus.wvalid  & bus.wready;
  assign b_hs   = bus.bvalid  & bus.bready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ADDR;
      ADDR:    if (aw_hs) state_d = DATA;
      DATA:    if (w_hs && bus.wlast) state_d = RESP;
      RESP:    if (b_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Line and address are snapshotted at acceptance; the cache may reuse the way afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beat_q <= '0;
      addr_q <= '0;
      line_q <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        addr_q <= bus.wb_addr & ~OFFS_MASK;
        line_q <= bus.wb_line;
        beat_q <= '0;
      end else if (w_hs) begin
        beat_q <= beat_q + 1'b1;
      end
      done_q <= b_hs;
      err_q  <= b_hs && (bus.bresp != RESP_OKAY);
    end
  end

  assign bus.wb_ready = (state_q == IDLE);
  assign bus.wb_done  = done_q;
  assign bus.wb_err   = err_q;

  assign bus.awaddr   = addr_q;
  assign bus.awlen    = 8'(LINE_WORDS - 1);
  assign bus.awsize   = SIZE_WORD;
  assign bus.awburst  = BURST_INCR;
  assign bus.awvalid  = (state_q == ADDR);

  assign bus.wdata    = line_q[32*beat_q +: 32];
  assign bus.wstrb    = 4'hF;
  assign bus.wlast    = (state_q == DATA) && (beat_q == LAST_BEAT);
  assign bus.wvalid   = (state_q == DATA);

  assign bus.bready   = (state_q == RESP);

  assign dbg_state    = state_q;

endmodule

// File: tb/tb_dcache_writeback.sv
// Bench for dcache_writeback: a table of directed bursts, randomized bursts against a
// transaction-level model, and hand sequences for held requests and mid-burst reset.
module tb_dcache_writeback;

  import dcache_pkg::*;

  localparam int LW = 4;
  localparam int AW = 32;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  wb_state_t dbg_state;

  dcache_writeback_if #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) bus ();

  dcache_writeback #(.LINE_WORDS(LW), .ADDR_WIDTH(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0]     addr;
    logic [LW*32-1:0] line;
    logic [1:0]      resp;
    int              aw_delay;
    logic [15:0]     wpat;
    int              b_delay;
    logic [31:0]     exp_awaddr;
    logic            exp_err;
    int              exp_lat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request-to-done cycles: pipeline minimum plus every AW stall, W stall and B delay.
  function automatic int lat_of(input int aw_delay, input logic [15:0] wpat, input int b_delay);
    int ones, zeros, k;
    logic r;
    ones = 0; zeros = 0; k = 0;
    while (ones < LW) begin
      r = (k < 16) ? wpat[k] : 1'b1;
      if (r) ones++;
      else zeros++;
      k++;
    end
    return LW + 3 + aw_delay + zeros + b_delay;
  endfunction

  task automatic run_txn(input string name, input logic [31:0] addr, input logic [LW*32-1:0] line,
                         input logic [1:0] resp, input int aw_delay, input logic [15:0] wpat,
                         input int b_delay, input bit hold_req, input logic [LW*32-1:0] nxt_line,
                         input bit spurious, input logic [31:0] exp_awaddr, input logic exp_err,
                         input int exp_lat);
    logic [31:0] exp_q[$];
    int  cyc, guard, aw_cnt, dcyc, bcnt, beats, b_exp_cyc;
    bit  aw_done, b_done, seen_done;
    logic rdy;
    for (int k = 0; k < LW; k++) exp_q.push_back(line[k*32 +: 32]);
    guard = 0;
    while (bus.wb_ready !== 1'b1 && guard < 100) begin
      tick();
      guard++;
    end
    check({name, "/idle_before"}, bus.wb_ready, 1'b1);
    if (bus.wb_ready !== 1'b1) return;
    bus.wb_req  = 1'b1;
    bus.wb_addr = addr;
    bus.wb_line = line;
    tick();
    bus.wb_req  = hold_req;
    bus.wb_addr = $urandom;
    bus.wb_line = nxt_line;
    cyc = 1; aw_done = 0; aw_cnt = 0; dcyc = 0; bcnt = 0; beats = 0;
    b_done = 0; seen_done = 0; b_exp_cyc = -1;
    while (!seen_done && cyc < 200) begin
      if (bus.wb_done === 1'b1) begin
        seen_done = 1;
        check({name, "/done_cycle"}, cyc, b_exp_cyc);
        check({name, "/latency"}, cyc, exp_lat);
        check({name, "/err"}, bus.wb_err, exp_err);
        check({name, "/beats"}, beats, LW);
        check({name, "/aw_cycles"}, aw_cnt, aw_delay + 1);
        check({name, "/ready_at_done"}, bus.wb_ready, 1'b1);
        check({name, "/valids_at_done"}, {bus.awvalid, bus.wvalid, bus.bready}, 3'b000);
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
      end else begin
        check({name, "/busy_flags"}, {bus.wb_ready, bus.wb_err}, 2'b00);
        check({name, "/awvalid"}, bus.awvalid, !aw_done);
        check({name, "/wvalid"}, bus.wvalid, aw_done && beats < LW);
        check({name, "/bready"}, bus.bready, beats == LW && !b_done);
        if (bus.awvalid === 1'b1) begin
          check({name, "/aw_fields"}, {bus.awaddr, bus.awlen, bus.awsize, bus.awburst},
                {exp_awaddr, 8'(LW - 1), 3'b010, 2'b01});
          rdy = (aw_cnt >= aw_delay);
          bus.awready = rdy;
          aw_cnt++;
          if (rdy) aw_done = 1;
        end else begin
          bus.awready = 1'($urandom_range(0, 1));
        end
        if (bus.wvalid === 1'b1 && beats < LW) begin
          check({name, "/wdata"}, bus.wdata, exp_q[beats]);
          check({name, "/wlast"}, bus.wlast, beats == LW - 1);
          check({name, "/wstrb"}, bus.wstrb, 4'hF);
          rdy = (dcyc < 16) ? wpat[dcyc] : 1'b1;
          bus.wready = rdy;
          dcyc++;
          if (rdy) beats++;
        end else begin
          bus.wready = 1'($urandom_range(0, 1));
        end
        if (bus.bready === 1'b1) begin
          rdy = (bcnt >= b_delay);
          bus.bvalid = rdy;
          bus.bresp  = resp;
          bcnt++;
          if (rdy) begin
            b_done = 1;
            b_exp_cyc = cyc + 1;
          end
        end else begin
          bus.bvalid = spurious;
          bus.bresp  = 2'b11;
        end
      end
      if (!seen_done) begin
        tick();
        cyc++;
      end
    end
    if (!seen_done) check({name, "/done_timeout"}, 1'b0, 1'b1);
    bus.awready = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    bus.bresp   = 2'b00;
    if (!hold_req) begin
      tick();
      check({name, "/after_done"}, {bus.wb_done, bus.wb_err, bus.wb_ready}, 3'b001);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [LW*32-1:0] l1, l2, lr;
    vecs[0] = '{32'h1000_003C, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 2'b00, 0, 16'hFFFF, 0,
                32'h1000_0030, 1'b0, 7};
    vecs[1] = '{32'h2000_0010, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                2'b00, 5, 16'hFFFF, 0, 32'h2000_0010, 1'b0, 12};
    vecs[2] = '{32'h0000_FFFF, {32'hB3, 32'hB2, 32'hB1, 32'hB0}, 2'b00, 0, 16'hFFE9, 0,
                32'h0000_FFF0, 1'b0, 10};
    vecs[3] = '{32'h8000_0004, {32'hC3, 32'hC2, 32'hC1, 32'hC0}, 2'b10, 0, 16'hFFFF, 0,
                32'h8000_0000, 1'b1, 7};
    vecs[4] = '{32'hDEAD_BEEF, {32'hD3, 32'hD2, 32'hD1, 32'hD0}, 2'b11, 2, 16'hFFFA, 3,
                32'hDEAD_BEE0, 1'b1, 14};
    vecs[5] = '{32'h0000_0020, {32'hE3, 32'hE2, 32'hE1, 32'hE0}, 2'b01, 0, 16'hFFFF, 1,
                32'h0000_0020, 1'b1, 8};

    bus.wb_req = 1'b0; bus.wb_addr = '0; bus.wb_line = '0;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;

    // Reset state
    reset = 1'b1;
    repeat (2) tick();
    check("reset/outputs", {bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.wb_done, bus.wb_err},
          6'b0);
    check("reset/wb_ready", bus.wb_ready, 1'b1);
    check("reset/aw_payload", bus.awaddr, 32'h0);
    reset = 1'b0;
    tick();
    check("post_reset/wb_ready", bus.wb_ready, 1'b1);

    for (int i = 0; i < 6; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].addr, vecs[i].line, vecs[i].resp, vecs[i].aw_delay,
              vecs[i].wpat, vecs[i].b_delay, 1'b0, {$urandom, $urandom, $urandom, $urandom},
              vecs[i].resp == 2'b00, vecs[i].exp_awaddr, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // Request held high with the line changing under the first burst
    l1 = {$urandom, $urandom, $urandom, $urandom};
    l2 = {$urandom, $urandom, $urandom, $urandom};
    run_txn("hold1", 32'h4000_1238, l1, 2'b00, 0, 16'hFFFF, 0, 1'b1, l2, 1'b0,
            32'h4000_1230, 1'b0, 7);
    run_txn("hold2", 32'h4000_1240, l2, 2'b00, 1, 16'hFFFF, 0, 1'b0, l1, 1'b0,
            32'h4000_1240, 1'b0, 8);

    // Reset while beat 2 is on the bus
    lr = {32'hF3, 32'hF2, 32'hF1, 32'hF0};
    bus.wb_req = 1'b1; bus.wb_addr = 32'h5000_0000; bus.wb_line = lr;
    tick();
    bus.wb_req = 1'b0;
    bus.awready = 1'b1; bus.wready = 1'b1;
    repeat (3) tick();
    check("rst_mid/beat2", {bus.wvalid, bus.wdata}, {1'b1, 32'hF2});
    #2 reset = 1'b1;
    #1;
    check("rst_mid/valids_low", {bus.awvalid, bus.wvalid, bus.wlast, bus.bready, bus.wb_done,
          bus.wb_err}, 6'b0);
    check("rst_mid/state", dbg_state, IDLE);
    tick();
    reset = 1'b0;
    bus.bvalid = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      check("rst_mid/no_done", {bus.wb_done, bus.wb_ready, bus.awvalid}, 3'b010);
    end
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0;
    run_txn("after_rst", vecs[0].addr, vecs[0].line, 2'b00, 0, 16'hFFFF, 0, 1'b0, '0, 1'b0,
            vecs[0].exp_awaddr, 1'b0, 7);

    // Randomized bursts against the transaction model
    for (int t = 0; t < 24; t++) begin
      logic [31:0]      a;
      logic [LW*32-1:0] ln;
      logic [1:0]       r;
      logic [15:0]      wp;
      int               ad, bd;
      a  = $urandom;
      ln = {$urandom, $urandom, $urandom, $urandom};
      r  = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      ad = $urandom_range(0, 3);
      wp = 16'($urandom);
      bd = $urandom_range(0, 3);
      run_txn($sformatf("rnd%0d", t), a, ln, r, ad, wp, bd, 1'b0,
              {$urandom, $urandom, $urandom, $urandom}, r == 2'b00,
              a & ~32'(LW * 4 - 1), r != 2'b00, lat_of(ad, wp, bd));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
